// File: rtl/set_time_field.sv
// rtl/set_time_field.sv - settable time field with edit/lock states, auto-repeat and BCD output
module set_time_field #(
  parameter int DIGITS   = 2,
  parameter int MAX_VAL  = 59,
  parameter int HOLD_CYC = 25_000_000,
  parameter int REP_CYC  = 5_000_000,
  localparam int VW      = $clog2(MAX_VAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  confirm,
  input  logic                  add,
  input  logic                  sub,
  input  logic                  load,
  input  logic [VW-1:0]         load_val,
  output logic [VW-1:0]         out_bin,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  locked,
  output logic                  wrap
);

  // Repeat counter must hold whichever of the two intervals is longer.
  localparam int LIM = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CW  = $clog2(LIM + 1);

  localparam logic [VW-1:0] MAX_V  = VW'(MAX_VAL);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD_CYC);
  localparam logic [CW-1:0] REP_V  = CW'(REP_CYC);

  typedef enum logic [1:0] {IDLE, EDIT, LOCKED} state_t;

  state_t          state;
  state_t          state_nx;
  logic            add_q;
  logic            sub_q;
  logic [CW-1:0]   cnt;
  logic            active;   // a single button is held after a press-edge step
  logic            phase;    // 0 = waiting out the initial hold, 1 = repeating

  logic            single;
  logic            add_edge;
  logic            sub_edge;
  logic [CW-1:0]   cnt_inc;
  logic            rep_hit;
  logic [VW-1:0]   load_clamped;
  logic [VW-1:0]   step_val;
  logic            step_wrap;
  logic [4*DIGITS-1:0] bcd;

  assign single       = add ^ sub;
  assign add_edge     = add & ~add_q & ~sub;
  assign sub_edge     = sub & ~sub_q & ~add;
  assign cnt_inc      = cnt + 1'b1;
  assign rep_hit      = active & (phase ? (cnt_inc == REP_V) : (cnt_inc == HOLD_V));
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // Next state: dropping en always returns to IDLE; confirm alone never unlocks.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = confirm ? LOCKED : EDIT;
      EDIT:    if (!en) state_nx = IDLE;
               else if (confirm) state_nx = LOCKED;
      LOCKED:  if (!en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One step in the direction of the held button, wrapping at both ends.
  always_comb begin
    step_val  = out_bin;
    step_wrap = 1'b0;
    if (add) begin
      if (out_bin >= MAX_V) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val = out_bin + 1'b1;
      end
    end else begin
      if (out_bin == '0) begin
        step_val  = MAX_V;
        step_wrap = 1'b1;
      end else begin
        step_val = out_bin - 1'b1;
      end
    end
  end

  // State, value and repeat tracking; load beats stepping and cancels any repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      locked  <= 1'b0;
      wrap    <= 1'b0;
      out_bin <= '0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      cnt     <= '0;
      active  <= 1'b0;
      phase   <= 1'b0;
    end else begin
      state  <= state_nx;
      locked <= (state_nx == LOCKED);
      add_q  <= add;
      sub_q  <= sub;
      wrap   <= 1'b0;
      if (state != LOCKED && load) begin
        out_bin <= load_clamped;
        active  <= 1'b0;
        cnt     <= '0;
        phase   <= 1'b0;
      end else if (state == EDIT && single) begin
        if (add_edge || sub_edge) begin
          out_bin <= step_val;
          wrap    <= step_wrap;
          active  <= 1'b1;
          cnt     <= '0;
          phase   <= 1'b0;
        end else if (active) begin
          if (rep_hit) begin
            out_bin <= step_val;
            wrap    <= step_wrap;
            cnt     <= '0;
            phase   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end else begin
        active <= 1'b0;
        cnt    <= '0;
        phase  <= 1'b0;
      end
    end
  end

  // Binary to BCD by shift-and-add-3, so out_bcd always tracks out_bin.
  always_comb begin
    bcd = '0;
    for (int i = VW - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*DIGITS-2:0], out_bin[i]};
    end
  end

  assign out_bcd = bcd;

endmodule

// File: tb/tb_set_time_field.sv
// tb/tb_set_time_field.sv - directed and randomized checks of set_time_field against a reference model
module tb_set_time_field;

  localparam int DIGITS   = 2;
  localparam int MAX_VAL  = 59;
  localparam int HOLD_CYC = 4;
  localparam int REP_CYC  = 2;
  localparam int VW       = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              confirm;
  logic              add;
  logic              sub;
  logic              load;
  logic [VW-1:0]     load_val;
  logic [VW-1:0]     out_bin;
  logic [4*DIGITS-1:0] out_bcd;
  logic              locked;
  logic              wrap;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int m_val;
  int m_mode;      // 0 idle, 1 edit, 2 locked
  int m_t;
  int m_press_t;
  bit m_active;
  bit m_add_q;
  bit m_sub_q;
  bit m_wrap;

  set_time_field #(
    .DIGITS(DIGITS), .MAX_VAL(MAX_VAL), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .confirm(confirm), .add(add), .sub(sub),
    .load(load), .load_val(load_val), .out_bin(out_bin), .out_bcd(out_bcd),
    .locked(locked), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    int x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_mode = 0; m_active = 0; m_add_q = 0; m_sub_q = 0; m_wrap = 0;
    m_press_t = 0;
  endtask

  task automatic bump(input bit up);
    if (up) begin
      if (m_val == MAX_VAL) begin m_val = 0; m_wrap = 1; end
      else m_val = m_val + 1;
    end else begin
      if (m_val == 0) begin m_val = MAX_VAL; m_wrap = 1; end
      else m_val = m_val - 1;
    end
  endtask

  task automatic model_edge();
    int d;
    m_wrap = 0;
    if (m_mode != 2 && load) begin
      m_val = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      m_active = 0;
    end else if (m_mode == 1 && (add ^ sub)) begin
      if ((add && !m_add_q) || (sub && !m_sub_q)) begin
        bump(add);
        m_active = 1;
        m_press_t = m_t;
      end else if (m_active) begin
        d = m_t - m_press_t;
        if (d == HOLD_CYC || (d > HOLD_CYC && (d - HOLD_CYC) % REP_CYC == 0)) bump(add);
      end
    end else begin
      m_active = 0;
    end
    case (m_mode)
      0: if (en) m_mode = confirm ? 2 : 1;
      1: if (!en) m_mode = 0; else if (confirm) m_mode = 2;
      default: if (!en) m_mode = 0;
    endcase
    m_add_q = add;
    m_sub_q = sub;
    m_t = m_t + 1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bin"},    32'(out_bin), 32'(m_val));
    check({tag, ".bcd"},    32'(out_bcd), 32'(to_bcd(m_val)));
    check({tag, ".locked"}, 32'(locked),  32'(m_mode == 2));
    check({tag, ".wrap"},   32'(wrap),    32'(m_wrap));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1; en = 0; confirm = 0; add = 0; sub = 0; load = 0; load_val = '0;
    m_t = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset.bin_const", 32'(out_bin), 32'd0);
    rst = 0;

    en = 1; tick("enter_edit");
    repeat (3) begin
      add = 1; tick("add_pulse");
      add = 0; tick("add_gap");
    end
    check("three.bin", 32'(out_bin), 32'd3);
    check("three.bcd", 32'(out_bcd), 32'h03);
    check("three.wrap", 32'(wrap), 32'd0);

    load = 1; load_val = 6'd0; tick("load0"); load = 0;
    sub = 1; tick("sub_wrap");
    check("subwrap.bin", 32'(out_bin), 32'd59);
    check("subwrap.bcd", 32'(out_bcd), 32'h59);
    check("subwrap.wrap", 32'(wrap), 32'd1);
    sub = 0; tick("sub_release");
    check("subwrap.wrap_off", 32'(wrap), 32'd0);
    add = 1; tick("add_wrap");
    check("addwrap.bin", 32'(out_bin), 32'd0);
    check("addwrap.wrap", 32'(wrap), 32'd1);
    add = 0; tick("add_release");

    load = 1; load_val = 6'd10; tick("load10"); load = 0;
    add = 1;
    for (int c = 1; c <= 10; c++) begin
      tick("hold_add");
      check("hold.bin", 32'(out_bin),
            32'(10 + int'(c >= 1) + int'(c >= 5) + int'(c >= 7) + int'(c >= 9)));
    end
    add = 0; tick("hold_release");
    check("hold.final", 32'(out_bin), 32'd14);

    add = 1; sub = 1;
    repeat (6) begin
      tick("both");
      check("both.bin", 32'(out_bin), 32'd14);
      check("both.wrap", 32'(wrap), 32'd0);
    end
    add = 0; tick("sub_left_held");
    check("both.no_edge", 32'(out_bin), 32'd14);
    sub = 0; tick("both_release");

    load = 1; load_val = 6'd63; tick("load63"); load = 0;
    check("clamp.bin", 32'(out_bin), 32'd59);
    confirm = 1; tick("confirm");
    check("lock.locked", 32'(locked), 32'd1);
    confirm = 0;
    repeat (2) begin
      add = 1; tick("locked_add");
      add = 0; tick("locked_gap");
    end
    load = 1; load_val = 6'd5; tick("locked_load"); load = 0;
    check("lock.bin", 32'(out_bin), 32'd59);
    check("lock.still", 32'(locked), 32'd1);
    en = 0; tick("unlock");
    check("unlock.locked", 32'(locked), 32'd0);

    en = 1; tick("reedit");
    load = 1; load_val = 6'd18; tick("load18"); load = 0;
    add = 1;
    repeat (6) tick("repeat_run");
    check("repeat.bin", 32'(out_bin), 32'd20);
    rst = 1; #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.bin_const", 32'(out_bin), 32'd0);
    tick("rst_held");
    tick("rst_held");
    rst = 0;
    repeat (3) tick("post_rst_add_high");
    check("post_rst.no_step", 32'(out_bin), 32'd0);
    add = 0; tick("post_rst_fall");
    add = 1; tick("post_rst_rise");
    check("post_rst.step", 32'(out_bin), 32'd1);
    add = 0; tick("post_rst_release");

    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 200) == 0);
      en       = ($urandom_range(0, 15) != 0);
      confirm  = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 5) == 0) add = ~add;
      if ($urandom_range(0, 5) == 0) sub = ~sub;
      load     = ($urandom_range(0, 25) == 0);
      load_val = 6'($urandom_range(0, 63));
      tick("random");
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/set_time_field.md
SET_TIME_FIELD -- requirements
Module: set_time_field

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits presented on out_bcd.
REQ-002 SHALL have parameter MAX_VAL, default 59: largest settable value; legal range 1..(10^DIGITS)-1.
REQ-003 SHALL have parameter HOLD_CYC, default 25_000_000: cycles a button is held after its first step before auto-repeat starts.
REQ-004 SHALL have parameter REP_CYC, default 5_000_000: cycles between auto-repeat steps.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  1 = field selected for setting.
REQ-008 SHALL have port confirm  input  1  1 = commit and lock the field.
REQ-009 SHALL have port add  input  1  increment button; synchronous and debounced upstream.
REQ-010 SHALL have port sub  input  1  decrement button; synchronous and debounced upstream.
REQ-011 SHALL have port load  input  1  1 = load load_val this cycle.
REQ-012 SHALL have port load_val  input  VW  binary preset value, where VW = clog2(MAX_VAL+1).
REQ-013 SHALL have port out_bin  output  VW  current value in binary, registered.
REQ-014 SHALL have port out_bcd  output  4*DIGITS  current value in BCD, least-significant digit in bits [3:0].
REQ-015 SHALL have port locked  output  1  1 while in state LOCKED.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse on every wrap-around step.

Function
REQ-017 SHALL implement three states.
- IDLE: en=0.
- EDIT: en=1 and not locked.
- LOCKED: value frozen.
REQ-018 SHALL make these transitions.
- IDLE->EDIT when en=1 and confirm=0.
- EDIT->LOCKED when confirm=1.
- EDIT->IDLE when en=0.
- LOCKED->IDLE when en=0; confirm alone never unlocks.
- IDLE with en=1 and confirm=1 SHALL go directly to LOCKED.
REQ-019 SHALL take steps only in EDIT; in IDLE and LOCKED, add and sub SHALL be ignored and repeat counters cleared.
REQ-020 SHALL register previous add/sub samples (add_q, sub_q). A press edge is add=1 & add_q=0 & sub=0, or the symmetric case for sub.
REQ-021 SHALL apply one step on the clock edge that samples a press edge, so out_bin changes one cycle after the input rises.
REQ-022 SHALL treat add=1 and sub=1 in the same cycle as no step. The hold counter SHALL clear and stay cleared until exactly one button is high again; the next step then requires a new press edge.
REQ-023 SHALL step again while a single button is held, HOLD_CYC cycles after the press-edge step. Further steps SHALL follow every REP_CYC cycles until release; release clears the counter.
REQ-024 SHALL wrap on increment: MAX_VAL+1 -> 0, with wrap=1 for that cycle.
REQ-025 SHALL wrap on decrement: 0-1 -> MAX_VAL, with wrap=1 for that cycle.
REQ-026 SHALL give load priority over add/sub in IDLE and EDIT. If load_val > MAX_VAL, out_bin SHALL load MAX_VAL.
REQ-027 SHALL ignore load in LOCKED.
REQ-028 SHALL not pulse wrap on a load, and SHALL not start a repeat sequence because of one.
REQ-029 SHALL derive out_bcd combinationally from out_bin, so both are always consistent in the same cycle.
REQ-030 SHALL never let out_bin exceed MAX_VAL.

Reset
REQ-031 SHALL, while rst=1, asynchronously force state=IDLE, out_bin=0, out_bcd=0, locked=0, wrap=0, add_q=0, sub_q=0, repeat counter=0.
REQ-032 SHALL, on rst=1 mid-edit or mid-repeat, abort immediately. After release, the first step SHALL require a new press edge even if add is still high.

Verification (DIGITS=2, MAX_VAL=59, HOLD_CYC=4, REP_CYC=2)
REQ-033 SHALL cover: reset, en=1, pulse add 3 times (1 cycle each, gaps) -> out_bin=3, out_bcd=8'h03, wrap=0.
REQ-034 SHALL cover: load 0 then pulse sub -> out_bin=59, out_bcd=8'h59, wrap=1 for exactly one cycle; then pulse add -> out_bin=0, wrap=1.
REQ-035 SHALL cover: from 10, hold add for 10 cycles -> steps at cycles 1, 5, 7, 9 -> out_bin=14.
REQ-036 SHALL cover: add and sub rise together and are held for 6 cycles -> out_bin unchanged, no wrap.
REQ-037 SHALL cover: load=1 with load_val=63 -> out_bin=59; confirm=1 -> locked=1; add pulses and load ignored; en=0 -> locked=0.
REQ-038 SHALL cover: assert rst during auto-repeat at 20 -> out_bin=0 immediately; release with add still high -> no step until add falls and rises.
